// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared constants and helpers for the parametrised pipeline stage
//           register (pipe_stage_buf) and its storage slot (pipe_entry).
// Rev     : 1.0  initial release
// ============================================================================
package pipe_pkg;

   // Buffering styles selectable through the MODE parameter
   localparam int MODE_PIPE = 0;   // single entry, combinational in_ready
   localparam int MODE_SKID = 1;   // two entries, registered in_ready

   // Instruction word presented while a slot carries a bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Part-select base of payload field k inside the packed data vector
   function automatic int fld(input int k, input int data_w);
      return k * data_w;
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
// Module  : pipe_entry
// Purpose : One storage slot of a pipeline stage: {valid, instr, pc, data}.
//           A load captures new contents and marks the slot valid.
//           A clear invalidates the slot and, with ZERO_BUBBLE set, also
//           turns the payload into a NOP so bubbles are visibly empty.
//           Load wins if both are raised. The enclosing stage never raises
//           both at once.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int PAY_W       = 96,
   parameter int ZERO_BUBBLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [31:0]      i_instr,
   input  logic [31:0]      i_pc,
   input  logic [PAY_W-1:0] i_data,
   output logic             o_valid,
   output logic [31:0]      o_instr,
   output logic [31:0]      o_pc,
   output logic [PAY_W-1:0] o_data
);

   logic             r_valid;
   logic [31:0]      r_instr;
   logic [31:0]      r_pc;
   logic [PAY_W-1:0] r_data;

   // Slot register: async clear on reset, load new entry or retire the old one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
         r_pc    <= 32'h0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_data  <= i_data;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         // Without zeroing the stale payload is kept so it can still be inspected
         if (ZERO_BUBBLE != 0) begin
            r_instr <= NOP_INSTR;
            r_pc    <= 32'h0;
            r_data  <= '0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_data  = r_data;

endmodule : pipe_entry
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_buf
// Purpose : Parametrised inter-stage pipeline register carrying instr, pc and
//           NFIELD payload words with a valid/ready handshake, synchronous
//           flush, optional bubble zeroing and a saturating bubble counter.
//           MODE_PIPE : one entry, in_ready = out_ready | ~out_valid.
//           MODE_SKID : main + skid entry, in_ready = ~skid_valid (a register),
//                       full throughput without a combinational ready path.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NFIELD      = 3,
   parameter int MODE        = 0,
   parameter int ZERO_BUBBLE = 1,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [31:0]              in_pc,
   input  logic [DATA_W*NFIELD-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [DATA_W*NFIELD-1:0] out_data,
   output logic [CNT_W-1:0]         bubble_cnt
);

   localparam int PAY_W = DATA_W * NFIELD;

   // Main (head) entry: always present, drives the stage outputs
   logic             w_main_valid;
   logic [31:0]      w_main_instr;
   logic [31:0]      w_main_pc;
   logic [PAY_W-1:0] w_main_data;
   logic             w_main_load;
   logic             w_main_clear;
   logic [31:0]      w_main_src_instr;
   logic [31:0]      w_main_src_pc;
   logic [PAY_W-1:0] w_main_src_data;

   // Handshake events, both evaluated at the same clock edge
   logic w_accept;
   logic w_pop;

   logic [CNT_W-1:0] r_bubble_cnt;

   assign w_accept = in_valid & in_ready;
   assign w_pop    = w_main_valid & out_ready;

   pipe_entry #(
      .PAY_W       (PAY_W),
      .ZERO_BUBBLE (ZERO_BUBBLE)
   ) u_main (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_instr (w_main_src_instr),
      .i_pc    (w_main_src_pc),
      .i_data  (w_main_src_data),
      .o_valid (w_main_valid),
      .o_instr (w_main_instr),
      .o_pc    (w_main_pc),
      .o_data  (w_main_data)
   );

   generate
      if (MODE == MODE_SKID) begin : g_skid
         logic             w_skid_valid;
         logic [31:0]      w_skid_instr;
         logic [31:0]      w_skid_pc;
         logic [PAY_W-1:0] w_skid_data;
         logic             w_skid_load;
         logic             w_skid_clear;

         pipe_entry #(
            .PAY_W       (PAY_W),
            .ZERO_BUBBLE (ZERO_BUBBLE)
         ) u_skid (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_instr (in_instr),
            .i_pc    (in_pc),
            .i_data  (in_data),
            .o_valid (w_skid_valid),
            .o_instr (w_skid_instr),
            .o_pc    (w_skid_pc),
            .o_data  (w_skid_data)
         );

         // Ready comes straight from the skid valid flop: room while skid is empty
         assign in_ready = ~w_skid_valid;

         // Main refills from skid when one is parked there, otherwise from input.
         // With skid occupied in_ready is low, so an accept never competes.
         assign w_main_load  = ~flush & ((w_accept & (~w_main_valid | w_pop)) |
                                         (w_pop & w_skid_valid));
         assign w_main_clear = flush | (w_pop & ~w_skid_valid & ~w_accept);

         // Skid captures the input only when main is busy and not draining
         assign w_skid_load  = ~flush & w_accept & w_main_valid & ~w_pop;
         assign w_skid_clear = flush | (w_pop & w_skid_valid);

         assign w_main_src_instr = w_skid_valid ? w_skid_instr : in_instr;
         assign w_main_src_pc    = w_skid_valid ? w_skid_pc    : in_pc;
         assign w_main_src_data  = w_skid_valid ? w_skid_data  : in_data;
      end else begin : g_pipe
         // Accept whenever the head is empty or leaving this cycle
         assign in_ready = out_ready | ~w_main_valid;

         assign w_main_load  = ~flush & w_accept;
         assign w_main_clear = flush | (w_pop & ~w_accept);

         assign w_main_src_instr = in_instr;
         assign w_main_src_pc    = in_pc;
         assign w_main_src_data  = in_data;
      end
   endgenerate

   // Bubble counter: one count per edge with no valid head, stuck at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bubble_cnt <= '0;
      end else if (!w_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign out_valid  = w_main_valid;
   assign out_instr  = w_main_instr;
   assign out_pc     = w_main_pc;
   assign bubble_cnt = r_bubble_cnt;

   // Field k of the head is routed to field k of the output, never reordered
   generate
      for (genvar k = 0; k < NFIELD; k++) begin : g_fld
         assign out_data[fld(k, DATA_W) +: DATA_W] = w_main_data[fld(k, DATA_W) +: DATA_W];
      end
   endgenerate

endmodule : pipe_stage_buf
`default_nettype wire
